// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
//
// Demand-actuated phase scheduler for a three-way junction with a main road
// (directions M1 and M2), a protected main-road turn (MT) and a side road (S).
//
// The controller rests in main green. Turn and side phases are served only
// when a latched request is pending. Side green is extended while a vehicle
// sits on the side stop line, up to a hard maximum. An emergency request
// walks the junction through the normal yellow and all-red clearance into a
// hold state with every approach red.
//
// Light encoding on every bus: red = 3'b100, yellow = 3'b010, green = 3'b001.
// The lights are a pure decode of the current state.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   req_mt          turn-lane detector; latches pend_mt
//   req_s           side-road detector; latches pend_s
//   side_presence   vehicle present on the side stop line (green extension)
//   emerg           emergency preempt request, level, synchronous to clk
//   light_M1        main direction 1 lights
//   light_M2        main direction 2 lights
//   light_MT        main turn lights
//   light_S         side road lights
//   phase           current state code (0..8)
//   pend_mt         turn request pending
//   pend_s          side request pending
//   preempt_active  high while holding in PREEMPT
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
    parameter int T_MIN_MAIN = 7,  // minimum main-green cycles before serving a request
    parameter int T_TURN     = 5,  // turn-green cycles
    parameter int T_SIDE     = 3,  // minimum side-green cycles
    parameter int T_SIDE_MAX = 8,  // maximum side-green cycles including extension
    parameter int T_YEL      = 2,  // cycles in every yellow state
    parameter int T_ALLRED   = 1,  // all-red clearance cycles
    parameter int CW         = 4   // dwell counter width, holds max(T_*) - 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_mt,
    input  logic       req_s,
    input  logic       side_presence,
    input  logic       emerg,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [3:0] phase,
    output logic       pend_mt,
    output logic       pend_s,
    output logic       preempt_active
);

    typedef enum logic [3:0] {
        MAIN_GREEN = 4'd0,
        M2_YEL     = 4'd1,
        TURN_GREEN = 4'd2,
        TURN_YEL   = 4'd3,
        MAIN_YEL   = 4'd4,
        SIDE_GREEN = 4'd5,
        SIDE_YEL   = 4'd6,
        ALL_RED    = 4'd7,
        PREEMPT    = 4'd8
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Last dwell-counter value of each timed state: a state of length T
    // lasts exactly T cycles, leaving on the cycle the counter reads T-1.
    localparam logic [CW-1:0] MAIN_LAST     = CW'(T_MIN_MAIN - 1);
    localparam logic [CW-1:0] TURN_LAST     = CW'(T_TURN - 1);
    localparam logic [CW-1:0] SIDE_MIN_LAST = CW'(T_SIDE - 1);
    localparam logic [CW-1:0] SIDE_MAX_LAST = CW'(T_SIDE_MAX - 1);
    localparam logic [CW-1:0] YEL_LAST      = CW'(T_YEL - 1);
    localparam logic [CW-1:0] ALLRED_LAST   = CW'(T_ALLRED - 1);

    state_t          state;
    state_t          state_next;
    state_t          next_after_red;
    state_t          after_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            pend_mt_next;
    logic            pend_s_next;
    logic            state_change;

    // -----------------------------------------------------------------------
    // State register (plus dwell counter, all-red target and pending bits)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses <= so every flop samples the values
            // from before the edge, independent of statement order.
            state          <= ALL_RED;
            cnt            <= '0;
            next_after_red <= MAIN_GREEN;
            pend_mt        <= 1'b0;
            pend_s         <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            next_after_red <= after_next;
            pend_mt        <= pend_mt_next;
            pend_s         <= pend_s_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // Yellow and all-red states only ever leave on their last dwell cycle, so
    // no input can shorten a clearance interval.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned (which would infer a latch).
        state_next = state;
        after_next = next_after_red;

        case (state)
            MAIN_GREEN: begin
                // Emergency abandons the minimum-green guarantee.
                if (emerg) begin
                    state_next = MAIN_YEL;
                end else if (cnt >= MAIN_LAST) begin
                    // Turn is served ahead of side; the side request stays
                    // latched and is picked up after the turn phase.
                    if (pend_mt) begin
                        state_next = M2_YEL;
                    end else if (pend_s) begin
                        state_next = MAIN_YEL;
                    end
                end
            end

            M2_YEL: begin
                // Only M2 clears for the turn; an emergency arriving now
                // diverts to clearing M1 as well.
                if (cnt == YEL_LAST) begin
                    state_next = emerg ? MAIN_YEL : TURN_GREEN;
                end
            end

            TURN_GREEN: begin
                if (emerg || cnt == TURN_LAST) begin
                    state_next = TURN_YEL;
                end
            end

            TURN_YEL: begin
                if (cnt == YEL_LAST) begin
                    state_next = ALL_RED;
                    if (emerg) begin
                        after_next = PREEMPT;
                    end else if (pend_s) begin
                        after_next = SIDE_GREEN;
                    end else begin
                        after_next = MAIN_GREEN;
                    end
                end
            end

            MAIN_YEL: begin
                if (cnt == YEL_LAST) begin
                    state_next = ALL_RED;
                    after_next = emerg ? PREEMPT : SIDE_GREEN;
                end
            end

            SIDE_GREEN: begin
                if (emerg) begin
                    state_next = SIDE_YEL;
                end else if (cnt >= SIDE_MIN_LAST &&
                             (!side_presence || cnt == SIDE_MAX_LAST)) begin
                    state_next = SIDE_YEL;
                end
            end

            SIDE_YEL: begin
                if (cnt == YEL_LAST) begin
                    state_next = ALL_RED;
                    after_next = emerg ? PREEMPT : MAIN_GREEN;
                end
            end

            ALL_RED: begin
                // A live emergency overrides whatever target was queued.
                if (cnt == ALLRED_LAST) begin
                    state_next = emerg ? PREEMPT : next_after_red;
                end
            end

            PREEMPT: begin
                if (!emerg) begin
                    state_next = ALL_RED;
                    after_next = MAIN_GREEN;
                end
            end

            default: begin
                // Corrupted state code: recover through a clearance interval.
                state_next = ALL_RED;
                after_next = MAIN_GREEN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Dwell counter and request latches
    // -----------------------------------------------------------------------
    assign state_change = (state_next != state);

    always_comb begin
        if (state_change) begin
            cnt_next = '0;
        end else if (state == MAIN_GREEN && cnt >= MAIN_LAST) begin
            // Main green is untimed; parking the counter at its threshold
            // keeps it from wrapping back under the minimum.
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    // A request is consumed on entry to the green it asked for. If the
    // detector is still active on that same edge, the clear wins so a single
    // vehicle is not served twice.
    always_comb begin
        pend_mt_next = pend_mt | req_mt;
        pend_s_next  = pend_s | req_s;
        if (state_change && state_next == TURN_GREEN) begin
            pend_mt_next = 1'b0;
        end
        if (state_change && state_next == SIDE_GREEN) begin
            pend_s_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // Green never appears on a conflicting pair: MT is green only with M2 red,
    // and S is green only with every main movement red.
    // -----------------------------------------------------------------------
    always_comb begin
        light_M1       = RED;
        light_M2       = RED;
        light_MT       = RED;
        light_S        = RED;
        phase          = state;
        preempt_active = 1'b0;

        case (state)
            MAIN_GREEN: begin
                light_M1 = GRN;
                light_M2 = GRN;
            end
            M2_YEL: begin
                light_M1 = GRN;
                light_M2 = YEL;
            end
            TURN_GREEN: begin
                light_M1 = GRN;
                light_MT = GRN;
            end
            TURN_YEL: begin
                light_M1 = YEL;
                light_MT = YEL;
            end
            MAIN_YEL: begin
                light_M1 = YEL;
                light_M2 = YEL;
            end
            SIDE_GREEN: begin
                light_S = GRN;
            end
            SIDE_YEL: begin
                light_S = YEL;
            end
            PREEMPT: begin
                preempt_active = 1'b1;
            end
            default: begin
                // ALL_RED and any illegal code show all red.
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//
// Self-checking bench for traffic_phase_scheduler. A behavioural model keeps
// the current phase, the cycles elapsed in it and the queued all-red target,
// and is stepped every clock from the junction rules. A compare process
// checks every DUT output against the model on each falling edge. Directed
// scenarios pin the model with hand-derived phase/duration traces, followed
// by a randomized soak with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

    localparam int T_MIN_MAIN = 7;
    localparam int T_TURN     = 5;
    localparam int T_SIDE     = 3;
    localparam int T_SIDE_MAX = 8;
    localparam int T_YEL      = 2;
    localparam int T_ALLRED   = 1;
    localparam int CW         = 4;

    localparam int P_MG  = 0;
    localparam int P_M2Y = 1;
    localparam int P_TG  = 2;
    localparam int P_TY  = 3;
    localparam int P_MY  = 4;
    localparam int P_SG  = 5;
    localparam int P_SY  = 6;
    localparam int P_AR  = 7;
    localparam int P_PRE = 8;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_mt;
    logic       req_s;
    logic       side_presence;
    logic       emerg;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [3:0] phase;
    logic       pend_mt;
    logic       pend_s;
    logic       preempt_active;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .T_MIN_MAIN (T_MIN_MAIN),
        .T_TURN     (T_TURN),
        .T_SIDE     (T_SIDE),
        .T_SIDE_MAX (T_SIDE_MAX),
        .T_YEL      (T_YEL),
        .T_ALLRED   (T_ALLRED),
        .CW         (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_mt         (req_mt),
        .req_s          (req_s),
        .side_presence  (side_presence),
        .emerg          (emerg),
        .light_M1       (light_M1),
        .light_M2       (light_M2),
        .light_MT       (light_MT),
        .light_S        (light_S),
        .phase          (phase),
        .pend_mt        (pend_mt),
        .pend_s         (pend_s),
        .preempt_active (preempt_active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    typedef struct packed {
        int   ph;     // current phase code
        int   t;      // whole cycles already spent in the phase
        int   after;  // where the next all-red clearance leads
        logic pmt;
        logic ps;
    } model_t;

    model_t m;

    // Fixed length of each timed phase; 0 for untimed/actuated phases.
    function automatic int phase_len(input int ph);
        case (ph)
            P_M2Y, P_TY, P_MY, P_SY: return T_YEL;
            P_TG:                    return T_TURN;
            P_AR:                    return T_ALLRED;
            default:                 return 0;
        endcase
    endfunction

    // Light table; bus 0..3 = M1, M2, MT, S.
    function automatic logic [2:0] light_of(input int ph, input int bus);
        logic [11:0] row;
        case (ph)
            P_MG:    row = {G, G, R, R};
            P_M2Y:   row = {G, Y, R, R};
            P_TG:    row = {G, R, G, R};
            P_TY:    row = {Y, R, Y, R};
            P_MY:    row = {Y, Y, R, R};
            P_SG:    row = {R, R, R, G};
            P_SY:    row = {R, R, R, Y};
            default: row = {R, R, R, R};
        endcase
        return row[11 - 3 * bus -: 3];
    endfunction

    function automatic model_t model_next(input model_t cur, input logic rq_mt,
                                          input logic rq_s, input logic pres,
                                          input logic em);
        model_t n;
        int     nx;
        int     af;
        bit     done;
        int     served;
        n    = cur;
        nx   = cur.ph;
        af   = cur.after;
        // After this edge the phase will have lasted t+1 cycles.
        served = cur.t + 1;
        done = (phase_len(cur.ph) != 0) && (served >= phase_len(cur.ph));
        case (cur.ph)
            P_MG: begin
                if (em) nx = P_MY;
                else if (served >= T_MIN_MAIN && cur.pmt) nx = P_M2Y;
                else if (served >= T_MIN_MAIN && cur.ps) nx = P_MY;
            end
            P_M2Y: if (done) nx = em ? P_MY : P_TG;
            P_TG:  if (em || done) nx = P_TY;
            P_TY:  if (done) begin
                nx = P_AR;
                af = em ? P_PRE : (cur.ps ? P_SG : P_MG);
            end
            P_MY:  if (done) begin
                nx = P_AR;
                af = em ? P_PRE : P_SG;
            end
            P_SG: begin
                if (em) nx = P_SY;
                else if (served >= T_SIDE && (!pres || served >= T_SIDE_MAX)) nx = P_SY;
            end
            P_SY:  if (done) begin
                nx = P_AR;
                af = em ? P_PRE : P_MG;
            end
            P_AR:  if (done) nx = em ? P_PRE : cur.after;
            P_PRE: if (!em) begin
                nx = P_AR;
                af = P_MG;
            end
            default: begin
                nx = P_AR;
                af = P_MG;
            end
        endcase
        n.pmt   = (cur.pmt | rq_mt) & !(nx == P_TG && cur.ph != P_TG);
        n.ps    = (cur.ps | rq_s) & !(nx == P_SG && cur.ph != P_SG);
        n.t     = (nx == cur.ph) ? served : 0;
        n.ph    = nx;
        n.after = af;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{ph: P_AR, t: 0, after: P_MG, pmt: 1'b0, ps: 1'b0};
        else        m <= model_next(m, req_mt, req_s, side_presence, emerg);
    end

    // -----------------------------------------------------------------------
    // Compare process: outputs are stable on the falling edge
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("phase",          phase,          m.ph);
            check("light_M1",       light_M1,       light_of(m.ph, 0));
            check("light_M2",       light_M2,       light_of(m.ph, 1));
            check("light_MT",       light_MT,       light_of(m.ph, 2));
            check("light_S",        light_S,        light_of(m.ph, 3));
            check("pend_mt",        pend_mt,        m.pmt);
            check("pend_s",         pend_s,         m.ps);
            check("preempt_active", preempt_active, m.ph == P_PRE);
            check("no_conflict",
                  (light_MT == G && light_M2 == G) ||
                  (light_S == G && (light_M1 == G || light_M2 == G || light_MT == G)),
                  0);
        end
    end

    // -----------------------------------------------------------------------
    // Directed scenario support: record outputs per falling edge E1..En
    // -----------------------------------------------------------------------
    int          n_tr;
    int          ph_tr [0:63];
    logic        pm_tr [0:63];
    logic        ps_tr [0:63];
    logic        pa_tr [0:63];
    logic [11:0] lt_tr [0:63];
    int          exp_runs[$];

    task automatic clear_inputs();
        req_mt        = 1'b0;
        req_s         = 1'b0;
        side_presence = 1'b0;
        emerg         = 1'b0;
    endtask

    // Ends on the falling edge E0 at which reset is released.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Inputs driven at E_i are the ones sampled by the following rising edge.
    task automatic scenario(input int n, input int mt_at, input int s_at,
                            input int em_from, input int em_to, input logic pres);
        n_tr = n;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            ph_tr[i] = int'(phase);
            pm_tr[i] = pend_mt;
            ps_tr[i] = pend_s;
            pa_tr[i] = preempt_active;
            lt_tr[i] = {light_M1, light_M2, light_MT, light_S};
            req_mt        = (i == mt_at);
            req_s         = (i == s_at);
            emerg         = (i >= em_from && i < em_to);
            side_presence = pres;
        end
        clear_inputs();
    endtask

    // Compress the recorded phases into (phase, length) runs and compare.
    task automatic check_trace(input string name);
        int runs[$];
        runs = {};
        for (int i = 1; i <= n_tr; i++) begin
            if (i > 1 && ph_tr[i] == ph_tr[i-1]) begin
                runs[runs.size() - 1] = runs[runs.size() - 1] + 1;
            end else begin
                runs.push_back(ph_tr[i]);
                runs.push_back(1);
            end
        end
        check($sformatf("%s_nruns", name), runs.size(), exp_runs.size());
        for (int i = 0; i < runs.size() && i < exp_runs.size(); i++) begin
            check($sformatf("%s_run%0d", name, i), runs[i], exp_runs[i]);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_phase",   phase,          4'd7);
        check("rst_M1",      light_M1,       3'b100);
        check("rst_M2",      light_M2,       3'b100);
        check("rst_MT",      light_MT,       3'b100);
        check("rst_S",       light_S,        3'b100);
        check("rst_pend_mt", pend_mt,        1'b0);
        check("rst_pend_s",  pend_s,         1'b0);
        check("rst_preempt", preempt_active, 1'b0);

        // Release: one all-red cycle, then main green held indefinitely
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_phase", phase, 4'd0);
        check("rel_M1",    light_M1, 3'b001);
        check("rel_S",     light_S,  3'b100);
        repeat (20) @(negedge clk);
        check("rest_phase", phase, 4'd0);
        check("rest_M2",    light_M2, 3'b001);
        check("rest_MT",    light_MT, 3'b100);

        // Turn request at main-green cnt=2
        do_reset();
        scenario(25, 3, 0, 0, 0, 1'b0);
        exp_runs = {P_MG, 7, P_M2Y, 2, P_TG, 5, P_TY, 2, P_AR, 1, P_MG, 8};
        check_trace("turn");
        check("turn_mg_lights",  lt_tr[1], 12'h264);
        check("turn_pend_set",   pm_tr[4], 1'b1);
        check("turn_pend_held",  pm_tr[9], 1'b1);
        check("turn_pend_clear", pm_tr[10], 1'b0);

        // Turn and side both requested: turn first, then side, then main
        do_reset();
        scenario(30, 3, 3, 0, 0, 1'b0);
        exp_runs = {P_MG, 7, P_M2Y, 2, P_TG, 5, P_TY, 2, P_AR, 1,
                    P_SG, 3, P_SY, 2, P_AR, 1, P_MG, 7};
        check_trace("both");
        check("both_ps_before_sg", ps_tr[17], 1'b1);
        check("both_pend_mt_end",  pm_tr[30], 1'b0);
        check("both_pend_s_end",   ps_tr[30], 1'b0);

        // Side served with presence held: extended to the maximum
        do_reset();
        scenario(28, 0, 3, 0, 0, 1'b1);
        exp_runs = {P_MG, 7, P_MY, 2, P_AR, 1, P_SG, 8, P_SY, 2, P_AR, 1, P_MG, 7};
        check_trace("ext");

        // Emergency at turn-green cnt=1, side request survives preemption
        do_reset();
        scenario(40, 3, 3, 11, 19, 1'b0);
        exp_runs = {P_MG, 7, P_M2Y, 2, P_TG, 2, P_TY, 2, P_AR, 1, P_PRE, 5, P_AR, 1,
                    P_MG, 7, P_MY, 2, P_AR, 1, P_SG, 3, P_SY, 2, P_AR, 1, P_MG, 4};
        check_trace("emerg");
        check("emerg_preempt_on",  pa_tr[16], 1'b1);
        check("emerg_lights_red",  lt_tr[16], 12'h924);
        check("emerg_ps_kept",     ps_tr[16], 1'b1);
        check("emerg_preempt_off", pa_tr[20], 1'b0);

        // Reset asserted mid side-yellow acts without waiting for a clock
        do_reset();
        scenario(14, 12, 3, 0, 0, 1'b0);
        exp_runs = {P_MG, 7, P_MY, 2, P_AR, 1, P_SG, 3, P_SY, 1};
        check_trace("arst");
        check("arst_pend_mt_before", pm_tr[14], 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst_phase",   phase,    4'd7);
        check("arst_M1",      light_M1, 3'b100);
        check("arst_M2",      light_M2, 3'b100);
        check("arst_MT",      light_MT, 3'b100);
        check("arst_S",       light_S,  3'b100);
        check("arst_pend_mt", pend_mt,  1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_recover", phase, 4'd0);

        // Randomized soak
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            req_mt = ($urandom_range(19) == 0);
            req_s  = ($urandom_range(15) == 0);
            if ($urandom_range(4) == 0) side_presence = ~side_presence;
            if (emerg) emerg = ($urandom_range(5) != 0);
            else       emerg = ($urandom_range(79) == 0);
            if (c % 1337 == 700) begin
                #3 reset = 1'b0;
                #4 reset = 1'b1;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-actuated phase scheduler for the three-way junction: main road (M1, M2), main-road turn (MT) and side road (S).
- Rests in main green. Serves turn and side phases only when a latched request is pending.
- Extends side green while a vehicle is present, and handles emergency preemption through proper yellow and all-red clearance.
- Drives the four light buses directly. Light encoding: red=3'b100, yellow=3'b010, green=3'b001.

Parameters:
- T_MIN_MAIN, 7: minimum main-green cycles before a request can be served
- T_TURN, 5: turn-green cycles
- T_SIDE, 3: minimum side-green cycles
- T_SIDE_MAX, 8: maximum side-green cycles including extension
- T_YEL, 2: cycles in every yellow state
- T_ALLRED, 1: all-red clearance cycles
- CW, 4: dwell counter width; must hold max(T_*) - 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_mt  in  1  turn-lane detector pulse/level; sets pend_mt
- req_s  in  1  side-road detector pulse/level; sets pend_s
- side_presence  in  1  vehicle present on side stop line (extension)
- emerg  in  1  emergency preempt request, level, synchronous to clk
- light_M1  out  3  main direction 1 lights
- light_M2  out  3  main direction 2 lights
- light_MT  out  3  main turn lights
- light_S  out  3  side road lights
- phase  out  4  current state code
- pend_mt  out  1  turn request pending
- pend_s  out  1  side request pending
- preempt_active  out  1  high in PREEMPT

Behaviour:
- State codes: MAIN_GREEN=0, M2_YEL=1, TURN_GREEN=2, TURN_YEL=3, MAIN_YEL=4, SIDE_GREEN=5, SIDE_YEL=6, ALL_RED=7, PREEMPT=8.
- Registers: state, dwell counter cnt, next_after_red (target of ALL_RED), pend_mt, pend_s. Lights are a pure decode of state.
- Reset (reset=0, async): state=ALL_RED, cnt=0, next_after_red=MAIN_GREEN, pend_*=0. All lights 3'b100, phase=7, preempt_active=0.
- cnt: cleared on every state change, else increments. A timed state of length T lasts exactly T cycles, i.e. it exits on the cycle cnt==T-1.
- Lights per state, as (M1, M2, MT, S):
  - MAIN_GREEN: G, G, R, R
  - M2_YEL: G, Y, R, R
  - TURN_GREEN: G, R, G, R
  - TURN_YEL: Y, R, Y, R
  - MAIN_YEL: Y, Y, R, R
  - SIDE_GREEN: R, R, R, G
  - SIDE_YEL: R, R, R, Y
  - ALL_RED and PREEMPT: R, R, R, R
- MAIN_GREEN (untimed rest):
  - emerg=1 goes to MAIN_YEL immediately, ignoring the minimum.
  - Otherwise, once cnt>=T_MIN_MAIN-1: pend_mt goes to M2_YEL; else pend_s goes to MAIN_YEL; else stay. cnt saturates at T_MIN_MAIN-1.
- M2_YEL (T_YEL): exits to TURN_GREEN, or to MAIN_YEL if emerg=1 on the exit cycle.
- TURN_GREEN (T_TURN): exits to TURN_YEL, early on the first cycle emerg=1.
- TURN_YEL (T_YEL): exits to ALL_RED. next_after_red = PREEMPT if emerg, SIDE_GREEN if pend_s, else MAIN_GREEN.
- MAIN_YEL (T_YEL): exits to ALL_RED. next_after_red = PREEMPT if emerg, else SIDE_GREEN.
- SIDE_GREEN:
  - Exits to SIDE_YEL immediately on emerg.
  - Otherwise, after cnt>=T_SIDE-1, exits when side_presence=0 or cnt==T_SIDE_MAX-1.
- SIDE_YEL (T_YEL): exits to ALL_RED. next_after_red = PREEMPT if emerg, else MAIN_GREEN.
- ALL_RED (T_ALLRED): exits to PREEMPT if emerg=1 on the exit cycle, overriding next_after_red; else exits to next_after_red.
- PREEMPT: holds while emerg=1. On emerg=0, goes to ALL_RED with next_after_red=MAIN_GREEN.
- Yellow and all-red dwell is never truncated by any input.
- Requests: pend_mt sets on req_mt=1 and clears on the transition into TURN_GREEN; pend_s likewise with req_s and SIDE_GREEN. If set and clear coincide, clear wins. Pending bits survive preemption.
- Invariant: never green on a conflicting pair. Checked pairs: MT vs M2, S vs any main. Illegal state codes return to ALL_RED with next=MAIN_GREEN.
- Reset asserted mid-phase forces ALL_RED instantly. The first state after release is MAIN_GREEN after T_ALLRED cycles.

Test Plan:
- Reset release, no requests -> 1 cycle ALL_RED, then MAIN_GREEN held indefinitely; lights M1=M2=001, MT=S=100.
- req_mt pulse 1 cycle at MAIN_GREEN cnt=2 -> pend_mt=1; M2_YEL entered after 7 main-green cycles; then TURN_GREEN 5, TURN_YEL 2, ALL_RED 1, MAIN_GREEN; pend_mt=0 on TURN_GREEN entry.
- req_mt and req_s both set in MAIN_GREEN -> order M2_YEL, TURN_GREEN, TURN_YEL, ALL_RED, SIDE_GREEN, SIDE_YEL, ALL_RED, MAIN_GREEN; both pend bits cleared.
- Side served, side_presence held 1 -> SIDE_GREEN lasts exactly 8 cycles. With side_presence=0 throughout it lasts exactly 3 cycles.
- emerg=1 at TURN_GREEN cnt=1 -> TURN_YEL next cycle, 2 cycles, ALL_RED 1, PREEMPT (all 100, preempt_active=1). emerg=0 -> ALL_RED 1, then MAIN_GREEN; pending pend_s still served afterwards.
- reset pulled low during SIDE_YEL -> all lights 100 within same cycle (async); pend_* cleared; recovery to MAIN_GREEN.
